sram_byte_ctrl: RTL and testbench

//  Memory-side slave behind the I/D arbiter: consumes mem_in_type, returns mem_out_type.

---
 rtl/sram_byte_ctrl_if.sv | 19 +
 rtl/sram_byte_ctrl.sv | 129 ++++++++++++
 tb/tb_sram_byte_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/sram_byte_ctrl_if.sv
// Request/response bundle between the I/D arbiter (master) and the byte-wide SRAM controller (slave).
interface sram_byte_ctrl_if;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_valid, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/sram_byte_ctrl.sv
// Splits 32-bit requests into byte cycles on an async 8-bit SRAM with programmable strobe wait states.
// Define SRAM_TURNAROUND_EN to insert one deselected TURN cycle between consecutive lanes.
module sram_byte_ctrl #(
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BITS   = 19
) (
  input  logic                 clock,
  input  logic                 reset,
  sram_byte_ctrl_if.slave      bus,
  output logic [ADDR_BITS-1:0] sram_addr,
  output logic [7:0]           sram_dq_o,
  input  logic [7:0]           sram_dq_i,
  output logic                 sram_dq_oe,
  output logic                 sram_ce_n,
  output logic                 sram_we_n,
  output logic                 sram_oe_n
);

  typedef enum logic [2:0] {IDLE, SETUP, STROBE, TURN, DONE} state_t;

  state_t                 state_reg, state_next;
  logic [1:0]             lane_reg;
  logic [3:0]             wait_reg;
  logic [ADDR_BITS-1:2]   addr_reg;
  logic [31:0]            wdata_reg;
  logic [3:0]             mask_reg;
  logic                   write_reg;
  logic [31:0]            rdata_reg;

  logic                   accept;
  logic [3:0]             req_mask;
  logic [1:0]             first_lane;
  logic                   has_next;
  logic [1:0]             next_lane;
  logic                   last_strobe;
  logic                   unused_addr_bits;

  assign unused_addr_bits = ^{bus.mem_addr[31:ADDR_BITS], bus.mem_addr[1:0]};

  assign accept      = bus.mem_valid && (state_reg == IDLE || state_reg == DONE);
  assign req_mask    = (bus.mem_wstrb == 4'b0000) ? 4'b1111 : bus.mem_wstrb;
  assign last_strobe = (state_reg == STROBE) && (wait_reg == 4'd0);

  // Lowest enabled lane of the incoming request.
  always_comb begin
    first_lane = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (req_mask[i]) first_lane = 2'(i);
    end
  end

  // Next enabled lane above the current one; disabled lanes cost no cycles.
  always_comb begin
    has_next  = 1'b0;
    next_lane = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (mask_reg[i] && (i > int'(lane_reg)) && !has_next) begin
        has_next  = 1'b1;
        next_lane = 2'(i);
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:   if (accept) state_next = SETUP;
      SETUP:  state_next = STROBE;
      STROBE: begin
        if (wait_reg == 4'd0) begin
          if (has_next) begin
`ifdef SRAM_TURNAROUND_EN
            state_next = TURN;
`else
            state_next = SETUP;
`endif
          end else begin
            state_next = DONE;
          end
        end
      end
      TURN:   state_next = SETUP;
      DONE:   state_next = accept ? SETUP : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg <= IDLE;
      lane_reg  <= 2'd0;
      wait_reg  <= 4'd0;
      addr_reg  <= '0;
      wdata_reg <= 32'd0;
      mask_reg  <= 4'd0;
      write_reg <= 1'b0;
      rdata_reg <= 32'd0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        addr_reg  <= bus.mem_addr[ADDR_BITS-1:2];
        wdata_reg <= bus.mem_wdata;
        mask_reg  <= req_mask;
        write_reg <= (bus.mem_wstrb != 4'b0000);
        lane_reg  <= first_lane;
        rdata_reg <= 32'd0;
      end
      if (state_reg == SETUP) begin
        wait_reg <= 4'(WAIT_CYCLES);
      end else if (state_reg == STROBE && wait_reg != 4'd0) begin
        wait_reg <= wait_reg - 4'd1;
      end
      if (last_strobe) begin
        if (!write_reg) rdata_reg[8*lane_reg +: 8] <= sram_dq_i;
        if (has_next) lane_reg <= next_lane;
      end
    end
  end

  assign sram_addr     = {addr_reg, lane_reg};
  assign sram_dq_o     = wdata_reg[8*lane_reg +: 8];
  assign sram_ce_n     = !(state_reg == SETUP || state_reg == STROBE);
  assign sram_we_n     = !(state_reg == STROBE && write_reg);
  assign sram_oe_n     = !(state_reg == STROBE && !write_reg);
  assign sram_dq_oe    = (state_reg == STROBE) && write_reg;
  assign bus.mem_ready = (state_reg == DONE);
  assign bus.mem_rdata = (state_reg == DONE && !write_reg) ? rdata_reg : 32'd0;

endmodule

// File: tb/tb_sram_byte_ctrl.sv
// Directed bench for sram_byte_ctrl with a 1-cycle-latency byte SRAM model (WAIT_CYCLES=1).
module tb_sram_byte_ctrl;
  localparam int WC = 1;
  localparam int AB = 19;
`ifdef SRAM_TURNAROUND_EN
  localparam int TURN = 1;
`else
  localparam int TURN = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [AB-1:0] sram_addr;
  logic [7:0]    sram_dq_o;
  logic [7:0]    sram_dq_i = 8'h00;
  logic          sram_dq_oe, sram_ce_n, sram_we_n, sram_oe_n;

  always #5 clock = ~clock;

  sram_byte_ctrl_if bus();

  sram_byte_ctrl #(.WAIT_CYCLES(WC), .ADDR_BITS(AB)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .sram_addr(sram_addr), .sram_dq_o(sram_dq_o), .sram_dq_i(sram_dq_i),
    .sram_dq_oe(sram_dq_oe), .sram_ce_n(sram_ce_n),
    .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
  );

  // Byte SRAM: read data appears one clock after oe_n is sampled low.
  logic [7:0] sram_mem [0:4095];
  always @(posedge clock) begin
    if (!sram_ce_n && !sram_oe_n) sram_dq_i <= sram_mem[sram_addr[11:0]];
    if (!sram_ce_n && !sram_we_n && sram_dq_oe) sram_mem[sram_addr[11:0]] <= sram_dq_o;
  end

  int          tot = 0;
  int          bad = 0;
  int          lat, n_log, we_cycles, ce_high;
  logic [31:0] got_rdata;
  logic [AB-1:0] addr_log [4];
  logic [7:0]  data_log [4];

  function automatic int exp_lat(input int n);
    return n * (WC + 2) + TURN * (n - 1) + 1;
  endfunction

  // Issues one request in the current cycle and records the bus activity until mem_ready.
  task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
    bit prev_strobe;
    bit done;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_wdata = wd;
    bus.mem_wstrb = ws;
    n_log = 0; we_cycles = 0; ce_high = 0; lat = -1; got_rdata = 32'hDEAD_BEEF;
    prev_strobe = 1'b0; done = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(posedge clock); #1;
      if (k == 1) bus.mem_valid = 1'b0;
      if (bus.mem_ready) begin
        lat = k; got_rdata = bus.mem_rdata; done = 1'b1;
      end else begin
        if (sram_ce_n) ce_high++;
        if (!sram_we_n) we_cycles++;
        if ((!sram_oe_n || !sram_we_n) && !prev_strobe && n_log < 4) begin
          addr_log[n_log] = sram_addr;
          data_log[n_log] = sram_dq_o;
          n_log++;
        end
        prev_strobe = !sram_oe_n || !sram_we_n;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    tot++; if (sram_ce_n !== 1'b1) begin bad++; $display("FAIL reset_ce_n got=%b want=1", sram_ce_n); end
    tot++; if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got=%b want=1", sram_we_n); end
    tot++; if (sram_oe_n !== 1'b1) begin bad++; $display("FAIL reset_oe_n got=%b want=1", sram_oe_n); end
    tot++; if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_dq_oe got=%b want=0", sram_dq_oe); end
    tot++; if (sram_addr !== '0) begin bad++; $display("FAIL reset_addr got=%h want=0", sram_addr); end
    tot++; if (sram_dq_o !== 8'h00) begin bad++; $display("FAIL reset_dq_o got=%h want=00", sram_dq_o); end
    tot++; if (bus.mem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", bus.mem_ready); end
    tot++; if (bus.mem_rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h want=0", bus.mem_rdata); end
    $display("reset: ce_n=%b we_n=%b oe_n=%b ready=%b", sram_ce_n, sram_we_n, sram_oe_n, bus.mem_ready);
    reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_read;
    logic [AB-1:0] want_a;
    sram_mem[12'h100] = 8'h11; sram_mem[12'h101] = 8'h22;
    sram_mem[12'h102] = 8'h33; sram_mem[12'h103] = 8'h44;
    do_req(32'h0000_0100, 32'h0, 4'b0000);
    $display("read 0x100: lat=%0d rdata=%h lanes=%0d ce_high=%0d", lat, got_rdata, n_log, ce_high);
    tot++; if (lat != exp_lat(4)) begin bad++; $display("FAIL read_latency got=%0d want=%0d", lat, exp_lat(4)); end
    tot++; if (got_rdata !== 32'h4433_2211) begin bad++; $display("FAIL read_rdata got=%h want=44332211", got_rdata); end
    tot++; if (n_log != 4) begin bad++; $display("FAIL read_lanes got=%0d want=4", n_log); end
    for (int i = 0; i < 4 && i < n_log; i++) begin
      want_a = AB'(32'h100 + i);
      tot++; if (addr_log[i] !== want_a) begin bad++; $display("FAIL read_addr%0d got=%h want=%h", i, addr_log[i], want_a); end
    end
    tot++; if (ce_high != 3 * TURN) begin bad++; $display("FAIL read_ce_gap got=%0d want=%0d", ce_high, 3 * TURN); end
    @(posedge clock); #1;
    tot++; if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      bad++; $display("FAIL read_ready_pulse got=%b/%h want=0/0", bus.mem_ready, bus.mem_rdata);
    end
  endtask

  task automatic test_write;
    for (int i = 0; i < 4; i++) sram_mem[12'h200 + i] = 8'h5A;
    do_req(32'h0000_0200, 32'hAABB_CCDD, 4'b0101);
    $display("write 0x200 strb=0101: lat=%0d rdata=%h we_cycles=%0d lanes=%0d", lat, got_rdata, we_cycles, n_log);
    tot++; if (lat != exp_lat(2)) begin bad++; $display("FAIL write_latency got=%0d want=%0d", lat, exp_lat(2)); end
    tot++; if (got_rdata !== 32'h0) begin bad++; $display("FAIL write_rdata got=%h want=0", got_rdata); end
    tot++; if (we_cycles != 4) begin bad++; $display("FAIL write_we_cycles got=%0d want=4", we_cycles); end
    tot++; if (n_log != 2) begin bad++; $display("FAIL write_lanes got=%0d want=2", n_log); end
    tot++; if (addr_log[0] !== AB'(32'h200) || data_log[0] !== 8'hDD) begin
      bad++; $display("FAIL write_lane0 got=%h/%h want=200/dd", addr_log[0], data_log[0]);
    end
    tot++; if (addr_log[1] !== AB'(32'h202) || data_log[1] !== 8'hBB) begin
      bad++; $display("FAIL write_lane2 got=%h/%h want=202/bb", addr_log[1], data_log[1]);
    end
    tot++; if ({sram_mem[12'h203], sram_mem[12'h202], sram_mem[12'h201], sram_mem[12'h200]} !== 32'h5ABB_5ADD) begin
      bad++; $display("FAIL write_mem got=%h want=5abb5add",
                      {sram_mem[12'h203], sram_mem[12'h202], sram_mem[12'h201], sram_mem[12'h200]});
    end
    @(posedge clock); #1;
    // High address bits alias; single top lane.
    do_req(32'h0008_0300, 32'h7700_0000, 4'b1000);
    $display("write 0x80300 strb=1000: lat=%0d addr=%h data=%h", lat, addr_log[0], data_log[0]);
    tot++; if (lat != exp_lat(1)) begin bad++; $display("FAIL alias_latency got=%0d want=%0d", lat, exp_lat(1)); end
    tot++; if (addr_log[0] !== AB'(32'h303) || data_log[0] !== 8'h77) begin
      bad++; $display("FAIL alias_lane3 got=%h/%h want=303/77", addr_log[0], data_log[0]);
    end
    @(posedge clock); #1;
  endtask

  task automatic test_back_to_back;
    do_req(32'h0000_0400, 32'hAABB_CCDD, 4'b1111);
    $display("write 0x400 strb=1111: lat=%0d rdata=%h", lat, got_rdata);
    tot++; if (lat != exp_lat(4)) begin bad++; $display("FAIL b2b_write_latency got=%0d want=%0d", lat, exp_lat(4)); end
    do_req(32'h0000_0400, 32'h0, 4'b0000);
    $display("read 0x400 in DONE: lat=%0d rdata=%h", lat, got_rdata);
    tot++; if (lat != exp_lat(4)) begin bad++; $display("FAIL b2b_read_latency got=%0d want=%0d", lat, exp_lat(4)); end
    tot++; if (got_rdata !== 32'hAABB_CCDD) begin bad++; $display("FAIL b2b_read_rdata got=%h want=aabbccdd", got_rdata); end
    @(posedge clock); #1;
  endtask

  task automatic test_reset_mid;
    int ready_seen;
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h100; bus.mem_wdata = 32'h0; bus.mem_wstrb = 4'b0000;
    @(posedge clock); #1;
    bus.mem_valid = 1'b0;
    repeat (7) @(posedge clock);
    #1;
    tot++; if (sram_addr[1:0] !== 2'd2) begin bad++; $display("FAIL abort_lane got=%0d want=2", sram_addr[1:0]); end
    reset = 1'b0;
    @(posedge clock); #1;
    tot++; if (sram_ce_n !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
      bad++; $display("FAIL abort_strobes got=%b%b%b%b want=1110", sram_ce_n, sram_we_n, sram_oe_n, sram_dq_oe);
    end
    tot++; if (sram_addr !== '0 || sram_dq_o !== 8'h00) begin
      bad++; $display("FAIL abort_addr_data got=%h/%h want=0/0", sram_addr, sram_dq_o);
    end
    tot++; if (bus.mem_ready !== 1'b0 || bus.mem_rdata !== 32'h0) begin
      bad++; $display("FAIL abort_resp got=%b/%h want=0/0", bus.mem_ready, bus.mem_rdata);
    end
    reset = 1'b1;
    ready_seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clock); #1;
      if (bus.mem_ready) ready_seen++;
    end
    $display("reset mid-read: ready pulses after abort=%0d", ready_seen);
    tot++; if (ready_seen != 0) begin bad++; $display("FAIL abort_no_ready got=%0d want=0", ready_seen); end
    sram_mem[12'h104] = 8'h01; sram_mem[12'h105] = 8'h02;
    sram_mem[12'h106] = 8'h03; sram_mem[12'h107] = 8'h80;
    do_req(32'h0000_0104, 32'h0, 4'b0000);
    $display("read 0x104 after abort: lat=%0d rdata=%h", lat, got_rdata);
    tot++; if (lat != exp_lat(4)) begin bad++; $display("FAIL fresh_latency got=%0d want=%0d", lat, exp_lat(4)); end
    tot++; if (got_rdata !== 32'h8003_0201) begin bad++; $display("FAIL fresh_rdata got=%h want=80030201", got_rdata); end
  endtask

  initial begin
    bus.mem_valid = 1'b0;
    bus.mem_addr  = 32'h0;
    bus.mem_wdata = 32'h0;
    bus.mem_wstrb = 4'h0;
    test_reset();
    test_read();
    test_write();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
